// File: rtl/axi_rd_slave_sram_if.sv
// AXI4 read-address and read-data channel bundle between the bus fabric and the SRAM read responder.
interface axi_rd_slave_sram_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_rd_slave_sram.sv
// AXI4 read responder for an on-chip SRAM: one AR burst at a time, FIXED/INCR/WRAP
// address walk, 1-cycle SRAM read latency, 2-entry R buffer under rready backpressure.
module axi_rd_slave_sram #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 4096
) (
  input  logic                         clk_i,
  input  logic                         arst_n,
  axi_rd_slave_sram_if.slave           ax,
  output logic                         mem_re_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  input  logic [DATA_W-1:0]            mem_rdata_i
);
  localparam int OFF  = $clog2(DATA_W/8);
  localparam int MA_W = $clog2(MEM_WORDS);
  localparam int WW   = ADDR_W - OFF;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} st_t;

  // wt marks an entry whose data is still arriving from the SRAM this cycle
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic              wt;
  } ent_t;

  st_t               st;
  logic              arready_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q, cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              berr_q;

  ent_t              fifo [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        cnt_f;

  logic unused_ok;
  assign unused_ok = ^{ax.arlock, ax.arcache, ax.arprot, ax.arqos, ax.arregion};

  // burst-level legality, evaluated on the AR beat itself
  logic [ADDR_W-1:0] ar_b;
  logic              ar_len_ok, ar_err;
  assign ar_b      = ADDR_W'(1) << ax.arsize;
  assign ar_len_ok = ax.arlen inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign ar_err    = (int'(ax.arsize) > OFF) || (ax.arburst == 2'b11) ||
                     ((ax.arburst == 2'b10) && (!ar_len_ok || ((ax.araddr & (ar_b - 1'b1)) != '0)));

  logic [WW-1:0]     word;
  logic              oor, can_issue;
  logic [1:0]        beat_resp;
  assign word      = addr_q[ADDR_W-1:OFF];
  assign oor       = word >= WW'(MEM_WORDS);
  // inflight reads already hold a buffer slot, so cnt_f covers buffer + inflight
  assign can_issue = (st == ISSUE) && (cnt_f < 2'd2);
  assign beat_resp = berr_q ? 2'b10 : (oor ? 2'b11 : 2'b00);
  assign mem_re_o  = can_issue && !berr_q && !oor;
  assign mem_addr_o = mem_re_o ? word[MA_W-1:0] : '0;

  logic [ADDR_W-1:0] b, wsz, nxt_addr;
  assign b   = ADDR_W'(1) << size_q;
  assign wsz = b * (ADDR_W'(len_q) + ADDR_W'(1));

  always_comb begin
    nxt_addr = addr_q;
    case (burst_q)
      2'b01:   nxt_addr = (addr_q & ~(b - 1'b1)) + b;
      2'b10:   nxt_addr = (addr_q & ~(wsz - 1'b1)) | ((addr_q + b) & (wsz - 1'b1));
      default: nxt_addr = addr_q;
    endcase
  end

  logic push, pop, rvalid_w;
  assign rvalid_w = cnt_f != 2'd0;
  assign pop      = rvalid_w && ax.rready;
  assign push     = can_issue;

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      st        <= IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      berr_q    <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          arready_q <= 1'b1;
          if (ax.arvalid && arready_q) begin
            id_q      <= ax.arid;
            addr_q    <= ax.araddr;
            len_q     <= ax.arlen;
            cnt_q     <= ax.arlen;
            size_q    <= ax.arsize;
            burst_q   <= ax.arburst;
            berr_q    <= ar_err;
            arready_q <= 1'b0;
            st        <= ISSUE;
          end
        end
        ISSUE: begin
          if (can_issue) begin
            addr_q <= nxt_addr;
            cnt_q  <= cnt_q - 8'd1;
            if (cnt_q == 8'd0) st <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_f == 2'd0) begin
            st        <= IDLE;
            arready_q <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt_f  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fifo[i].wt) begin
          fifo[i].data <= mem_rdata_i;
          fifo[i].wt   <= 1'b0;
        end
      end
      if (push) begin
        fifo[wr_ptr].id   <= id_q;
        fifo[wr_ptr].data <= '0;
        fifo[wr_ptr].resp <= beat_resp;
        fifo[wr_ptr].last <= cnt_q == 8'd0;
        fifo[wr_ptr].wt   <= mem_re_o;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt_f <= cnt_f + 2'(push) - 2'(pop);
    end
  end

  // head bypasses SRAM data in its arrival cycle; captured copy holds it while stalled
  ent_t head;
  assign head       = fifo[rd_ptr];
  assign ax.arready = arready_q;
  assign ax.rvalid  = rvalid_w;
  assign ax.rid     = rvalid_w ? head.id : '0;
  assign ax.rresp   = rvalid_w ? head.resp : 2'b00;
  assign ax.rlast   = rvalid_w && head.last;
  assign ax.rdata   = !rvalid_w ? '0 : (head.wt ? mem_rdata_i : head.data);

endmodule

// File: tb/tb_axi_rd_slave_sram.sv
// Randomized bench for axi_rd_slave_sram: SRAM model, burst-level reference model, R/mem scoreboards.
module tb_axi_rd_slave_sram;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64, MEM_WORDS = 4096;

  logic clk_i = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  axi_rd_slave_sram_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ax();
  logic        mem_re_o;
  logic [11:0] mem_addr_o;
  logic [63:0] mem_rdata_i = '0;

  axi_rd_slave_sram #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk_i(clk_i), .arst_n(arst_n), .ax(ax),
    .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mval(input longint w);
    return {32'hC0DE_0000 | 32'(w), 32'h5A5A_5A5A ^ 32'(w * 7)};
  endfunction

  always @(posedge clk_i) if (mem_re_o) mem_rdata_i <= mval(longint'(mem_addr_o));

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t  expq[$];
  longint maddrq[$];
  int     nbeats = 0;

  // expected beats straight from the burst rules: i-th address in closed form
  task automatic model_burst(input logic [3:0] id, input longint unsigned addr, input int len,
                             input int size, input int burst);
    longint unsigned b, w, base, a, word;
    bit err;
    beat_t e;
    b   = longint'(1) << size;
    err = (size > 3) || (burst == 3) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
          (burst == 2 && (addr % b) != 0);
    for (int i = 0; i <= len; i++) begin
      case (burst)
        1: a = (i == 0) ? addr : (((addr / b) * b + i * b) % (longint'(1) << 32));
        2: begin
          w = b * (len + 1);
          base = (addr / w) * w;
          a = base + ((addr - base + i * b) % w);
        end
        default: a = addr;
      endcase
      word = a >> 3;
      e.id = id;
      e.last = (i == len);
      if (err) begin
        e.resp = 2'b10; e.data = '0;
      end else if (word >= MEM_WORDS) begin
        e.resp = 2'b11; e.data = '0;
      end else begin
        e.resp = 2'b00; e.data = mval(longint'(word));
        maddrq.push_back(longint'(word));
      end
      expq.push_back(e);
    end
  endtask

  // scoreboard: SRAM reads, R beats, stall stability
  bit          stalled = 0;
  logic [63:0] s_data;
  logic [7:0]  s_meta;
  always @(negedge clk_i) begin
    if (arst_n) begin
      if (mem_re_o) begin
        if (maddrq.size() == 0) chk("mem_extra", 1, 0);
        else chk("mem_addr", 64'(mem_addr_o), 64'(maddrq.pop_front()));
      end
      if (stalled) begin
        chk("stall_vld", 64'(ax.rvalid), 1);
        chk("stall_data", ax.rdata, s_data);
        chk("stall_meta", 64'({ax.rid, ax.rresp, ax.rlast}), 64'(s_meta));
      end
      stalled = ax.rvalid && !ax.rready;
      s_data = ax.rdata;
      s_meta = 8'({ax.rid, ax.rresp, ax.rlast});
      if (ax.rvalid && ax.rready) begin
        if (expq.size() == 0) chk("r_extra", 1, 0);
        else begin
          beat_t e;
          e = expq.pop_front();
          chk("rid", 64'(ax.rid), 64'(e.id));
          chk("rdata", ax.rdata, e.data);
          chk("rresp", 64'(ax.rresp), 64'(e.resp));
          chk("rlast", 64'(ax.rlast), 64'(e.last));
        end
        nbeats++;
      end
    end
  end

  int rr_mode = 0, pat_i = 0;
  initial begin
    ax.rready = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (rr_mode)
        0: ax.rready = 1'b1;
        1: ax.rready = 1'($urandom % 2);
        default: begin ax.rready = (pat_i % 3 == 0); pat_i++; end
      endcase
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
    bit ok = 0;
    @(posedge clk_i); #1;
    ax.arvalid = 1'b1; ax.arid = id; ax.araddr = addr; ax.arlen = 8'(len);
    ax.arsize = 3'(size); ax.arburst = 2'(burst);
    ax.arlock = 1'($urandom); ax.arcache = 4'($urandom); ax.arprot = 3'($urandom);
    ax.arqos = 4'($urandom); ax.arregion = 4'($urandom);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_i);
      if (ax.arready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("ar_timeout", 0, 1);
      ax.arvalid = 1'b0;
    end else begin
      @(posedge clk_i);
      model_burst(id, longint'(addr), len, size, burst);
      #1 ax.arvalid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk_i);
      if (expq.size() == 0 && maddrq.size() == 0 && ax.arready) return;
    end
    chk("drain_timeout", 0, 1);
  endtask

  initial begin
    ax.arvalid = 1'b0; ax.arid = '0; ax.araddr = '0; ax.arlen = '0; ax.arsize = '0;
    ax.arburst = '0; ax.arlock = '0; ax.arcache = '0; ax.arprot = '0; ax.arqos = '0;
    ax.arregion = '0;

    // reset state
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_arready", 64'(ax.arready), 0);
    chk("rst_rvalid", 64'(ax.rvalid), 0);
    chk("rst_rlast", 64'(ax.rlast), 0);
    chk("rst_rdata", ax.rdata, 0);
    chk("rst_rid", 64'(ax.rid), 0);
    chk("rst_mem_re", 64'(mem_re_o), 0);
    chk("rst_mem_addr", 64'(mem_addr_o), 0);
    @(negedge clk_i) arst_n = 1'b1;
    @(posedge clk_i); #1;
    chk("rel_arready", 64'(ax.arready), 1);

    // INCR 4 beats with latency and back-to-back beat checks
    send_ar(4'd3, 32'h100, 3, 3, 1);
    chk("t1_mem_re", 64'(mem_re_o), 1);
    chk("t1_mem_addr0", 64'(mem_addr_o), 64'h20);
    chk("t1_arready_busy", 64'(ax.arready), 0);
    @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_rvalid_seq", 64'(ax.rvalid), 1);
      @(posedge clk_i); #1;
    end
    wait_done();

    send_ar(4'd5, 32'h18, 3, 3, 2);
    wait_done();

    rr_mode = 2; pat_i = 0;
    send_ar(4'd9, 32'h40, 2, 3, 0);
    wait_done();
    rr_mode = 0;

    // burst error: no SRAM access expected, 2 SLVERR beats
    send_ar(4'd1, 32'h80, 1, 4, 1);
    wait_done();
    chk("err_arready", 64'(ax.arready), 1);

    send_ar(4'd2, 32'(longint'(MEM_WORDS - 1) * 8), 1, 3, 1);
    wait_done();

    // async reset after 2 of 8 beats
    begin
      int n0 = nbeats;
      bit ok = 0;
      send_ar(4'd7, 32'h200, 7, 3, 1);
      for (int k = 0; k < 200; k++) begin
        @(negedge clk_i);
        if (nbeats >= n0 + 2) begin ok = 1; break; end
      end
      if (!ok) chk("rst_mid_timeout", 0, 1);
      #2 arst_n = 1'b0;
      #1;
      chk("mid_rvalid", 64'(ax.rvalid), 0);
      chk("mid_mem_re", 64'(mem_re_o), 0);
      expq.delete(); maddrq.delete(); stalled = 0;
      @(negedge clk_i) arst_n = 1'b1;
      @(posedge clk_i); #1;
      chk("mid_rel_arready", 64'(ax.arready), 1);
      send_ar(4'd4, 32'h300, 3, 3, 1);
      wait_done();
    end

    // randomized bursts under random backpressure
    rr_mode = 1;
    for (int t = 0; t < 40; t++) begin
      int burst, size, len;
      logic [31:0] addr;
      burst = ($urandom % 8 == 7) ? 3 : int'($urandom % 3);
      size  = ($urandom % 10 == 0) ? 4 + int'($urandom % 4) : int'($urandom % 4);
      if (burst == 2) begin
        case ($urandom % 5)
          0: len = 1; 1: len = 3; 2: len = 7; 3: len = 15;
          default: len = int'($urandom % 16);
        endcase
      end else len = int'($urandom % 16);
      addr = 32'($urandom_range(0, 32'h8100));
      if ($urandom % 4 != 0) addr = addr & ~32'((1 << size) - 1);
      send_ar(4'($urandom), addr, len, size, burst);
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_slave_sram.md
Name: axi_rd_slave_sram

Overview:
AXI4 read-channel responder; the slave end of the AR channel plus the R channel it drives. Accepts one AR burst at a time, walks the burst address sequence (FIXED/INCR/WRAP), issues single-cycle-latency SRAM reads and returns R beats with rid/rresp/rlast under full rready backpressure. Sits between the core bus fabric and an on-chip SRAM (boot ROM / scratchpad).

Parameters:
ID_W, 4, width of arid/rid (matches BUS_ID_W)
ADDR_W, 32, width of araddr (matches PADDR)
DATA_W, 64, R data width; power of two, 32..256
MEM_WORDS, 4096, SRAM depth in DATA_W words; beats addressing beyond it return DECERR

Ports:
clk_i  in  1  clock, all logic rising-edge
arst_n  in  1  reset, asynchronous, active-low
arid  in  ID_W  burst ID
araddr  in  ADDR_W  start byte address
arlen  in  8  beats-1
arsize  in  3  log2 bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
arlock, arcache, arprot, arqos, arregion  in  1/4/3/4/4  accepted, ignored
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_W  echoed arid
rdata  out  DATA_W  read data
rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
mem_re_o  out  1  SRAM read enable
mem_addr_o  out  $clog2(MEM_WORDS)  SRAM word address
mem_rdata_i  in  DATA_W  SRAM data, valid cycle after mem_re_o

Behaviour:
- Reset: arready=0 while arst_n low, 1 in first cycle after release; rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, mem_re_o=0, mem_addr_o=0; FSM=IDLE; buffer empty; counters 0.
- FSM IDLE: arready=1; on arvalid&arready latch id/addr/len/size/burst, set beat counter = arlen, check errors -> ISSUE. Never accept a new AR outside IDLE (arready=0).
- Error check at accept (whole burst SLVERR, no SRAM reads, rdata=0): arsize > log2(DATA_W/8); arburst=11; WRAP with arlen not in {1,3,7,15}; WRAP with araddr not aligned to 2^arsize.
- ISSUE: per beat, if (buffer_count + inflight) < 2: in-range non-error beat asserts mem_re_o one cycle with mem_addr_o = addr[ADDR_W-1:log2(DATA_W/8)]; error/out-of-range beat pushes response directly with rdata=0 (DECERR if word index >= MEM_WORDS, SLVERR for burst error). Advance address, decrement counter; after beat with counter 0 -> DRAIN.
- Address update, B=2^size: FIXED unchanged; INCR next = (addr & ~(B-1)) + B, ADDR_W wrap-around, no 4KB check; WRAP W=B*(len+1), next = (addr & ~(W-1)) | ((addr+B) & (W-1)).
- R buffer: 2-entry FIFO of {id,data,resp,last}; SRAM data captured cycle after mem_re_o. Head drives R outputs; pop on rvalid&rready. Outputs stable while rvalid&!rready. Simultaneous push and pop allowed.
- rlast=1 only on beat arlen+1. Exactly arlen+1 beats per burst, in order.
- DRAIN: wait until buffer empty and no read inflight -> IDLE (arready=1 next cycle).
- Latency: arvalid&arready at cycle T -> mem_re_o T+1 -> first rvalid T+2. With rready held high, one beat per cycle sustained.
- Async reset mid-burst: all state cleared immediately; pending beats discarded.

Test Plan:
- INCR 4 beats, arid=3, araddr=0x100, arsize=3, rready=1 -> mem_addr 0x20,0x21,0x22,0x23; rvalid from T+2, 4 consecutive beats, rid=3, rresp=00, rlast on 4th only.
- WRAP arlen=3, arsize=3, araddr=0x18 -> word addresses 0x3,0x0,0x1,0x2; rlast on 4th.
- FIXED arlen=2, araddr=0x40 with rready toggling 1,0,0,1,... -> three beats all word 0x8; R outputs stable while stalled; no beat lost/duplicated.
- Error: arsize=4 (DATA_W=64), arlen=1 -> no mem_re_o, 2 beats rresp=10, rdata=0, rlast on 2nd; arready returns after drain.
- INCR arlen=1 starting at last word MEM_WORDS-1 -> beat0 OKAY, beat1 DECERR.
- arst_n low mid-burst (after 2 of 8 beats) -> rvalid=0 immediately, arready=1 first cycle after release; next burst returns correct data.
